// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data memory block.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package data_mem_pkg;

  // Default geometry: 32 words of 8 bits on a 5-bit address bus
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 32;

  // Two-state controller: sweeping zeros into the array, or serving requests
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Width of a word index for a given depth, never below one bit
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one synchronous read port.
// Latency: write lands at the clock edge; read data appears one edge after rd_en.
// Backpressure: none; the controller above decides when either port fires.
module data_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_dat
);

  // Index bound, one bit wider than the index so DEPTH itself is representable
  localparam logic [IDX_W:0] DEPTH_CMP = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_dat_q;
  logic [DATA_W-1:0] rd_dat_d;
  logic              wr_ok;
  logic              rd_ok;

  // Guard both ports so a non-power-of-two depth never touches a missing row
  always_comb begin
    wr_ok = wr_en && ({1'b0, wr_idx} < DEPTH_CMP);
    rd_ok = rd_en && ({1'b0, rd_idx} < DEPTH_CMP);
  end

  // Write port: storage carries no reset, the clear sweep initialises it
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_idx] <= wr_dat;
    end
  end

  // Read port next value: capture the addressed word, otherwise hold
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_ok) begin
      rd_dat_d = mem_q[rd_idx];
    end
  end

  // Read port register, left unreset so it maps onto plain RAM output latches
  always_ff @(posedge clk) begin
    rd_dat_q <= rd_dat_d;
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/data_mem.sv
// Single-port data memory with req/ready handshake, range checking and a hardware clear sweep.
// Latency: reads return rvalid/rdata one cycle after acceptance; writes commit at the accepting edge.
// Backpressure: ready is low for DEPTH cycles per clear sweep; requesters hold req until ready.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int IDX_W = idx_width(DEPTH);

  // Range bound at ADDR_W+1 bits so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0]  DEPTH_CMP = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  // Controller state and sweep index
  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Response registers; rzero_q forces rdata to zero after reset or an out-of-range read
  logic             rvalid_q;
  logic             rvalid_d;
  logic             err_q;
  logic             err_d;
  logic             rzero_q;
  logic             rzero_d;

  // Request decode
  logic             acc;
  logic             acc_rd;
  logic             acc_wr;
  logic             in_range;
  logic [IDX_W-1:0] addr_idx;

  // Array port controls
  logic             arr_wr_en;
  logic [IDX_W-1:0] arr_wr_idx;
  logic [DATA_W-1:0] arr_wr_dat;
  logic             arr_rd_en;
  logic [DATA_W-1:0] arr_rd_dat;

  // Decode the incoming request; acceptance depends only on registered state
  always_comb begin
    in_range = ({1'b0, addr} < DEPTH_CMP);
    addr_idx = addr[IDX_W-1:0];
    acc      = req && (state_q == ST_IDLE);
    acc_rd   = acc && !we;
    acc_wr   = acc && we;
  end

  // State register: async reset drops straight back into a fresh sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: sweep 0..DEPTH-1 then idle; clr always restarts the sweep at zero
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr) begin
          idx_d = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // State outputs: ready and the array port mux (sweep zeros vs. request data)
  always_comb begin
    ready      = 1'b0;
    arr_wr_en  = 1'b0;
    arr_wr_idx = addr_idx;
    arr_wr_dat = wdata;
    arr_rd_en  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        arr_wr_en  = 1'b1;
        arr_wr_idx = idx_q;
        arr_wr_dat = '0;
      end
      ST_IDLE: begin
        ready     = 1'b1;
        arr_wr_en = acc_wr && in_range;
        arr_rd_en = acc_rd && in_range;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  // Response next values: one-cycle pulses, and rdata qualifier held between reads
  always_comb begin
    rvalid_d = acc_rd;
    err_d    = acc && !in_range;
    rzero_d  = rzero_q;
    if (acc_rd) begin
      rzero_d = !in_range;
    end
  end

  // Response registers: reset kills any pending pulse and zeroes rdata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rzero_q  <= 1'b1;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rzero_q  <= rzero_d;
    end
  end

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk    (clk),
    .wr_en  (arr_wr_en),
    .wr_idx (arr_wr_idx),
    .wr_dat (arr_wr_dat),
    .rd_en  (arr_rd_en),
    .rd_idx (addr_idx),
    .rd_dat (arr_rd_dat)
  );

  // rdata comes from the array read register, masked by a registered zero flag
  assign rdata  = rzero_q ? '0 : arr_rd_dat;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: a DEPTH=32 and a DEPTH=24 instance side by side.
// Latency: responses sampled 1 time unit after the edge that produced them.
// Backpressure: clear windows counted cycle by cycle against hand-computed ready.
module tb_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clr0, req0, we0, ready0, rvalid0, err0;
  logic [4:0] addr0;
  logic [7:0] wdata0, rdata0;
  logic       clr1, req1, we1, ready1, rvalid1, err1;
  logic [4:0] addr1;
  logic [7:0] wdata1, rdata1;

  int n_chk;
  int n_fail;

  data_mem #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0)
  );

  data_mem #(.DATA_W(8), .ADDR_W(5), .DEPTH(24)) u_d24 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .req(req1), .we(we1), .addr(addr1),
    .wdata(wdata1), .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .err(err1)
  );

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       ev;
    logic [7:0] erd;
    logic       ee;
  } vec_t;

  vec_t tbl [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [4:0] a,
                       input logic [7:0] wd, input logic c);
    if (d == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = wd; clr0 = c;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = wd; clr1 = c;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic o_ready(input int d);
    return (d == 0) ? ready0 : ready1;
  endfunction
  function automatic logic o_rvalid(input int d);
    return (d == 0) ? rvalid0 : rvalid1;
  endfunction
  function automatic logic o_err(input int d);
    return (d == 0) ? err0 : err1;
  endfunction
  function automatic logic [7:0] o_rdata(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);

    // DEPTH=24 vectors, applied back to back; erd tracks rdata hold behaviour
    tbl[0]  = '{1'b1, 5'd7,  8'hA5, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 5'd7,  8'h00, 1'b1, 8'hA5, 1'b0};
    tbl[2]  = '{1'b1, 5'd30, 8'h11, 1'b0, 8'hA5, 1'b1};
    tbl[3]  = '{1'b0, 5'd30, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[4]  = '{1'b0, 5'd6,  8'h00, 1'b1, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 5'd6,  8'h5A, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 5'd23, 8'hC3, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 5'd24, 8'hFF, 1'b0, 8'h00, 1'b1};
    tbl[8]  = '{1'b0, 5'd23, 8'h00, 1'b1, 8'hC3, 1'b0};
    tbl[9]  = '{1'b0, 5'd24, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[10] = '{1'b0, 5'd6,  8'h00, 1'b1, 8'h5A, 1'b0};
    tbl[11] = '{1'b0, 5'd7,  8'h00, 1'b1, 8'hA5, 1'b0};
    tbl[12] = '{1'b1, 5'd31, 8'h77, 1'b0, 8'hA5, 1'b1};
    tbl[13] = '{1'b0, 5'd31, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[14] = '{1'b0, 5'd0,  8'h00, 1'b1, 8'h00, 1'b0};

    // Reset values on both instances
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready_d%0d", d),  o_ready(d),  1'b0);
      chk($sformatf("rst_rvalid_d%0d", d), o_rvalid(d), 1'b0);
      chk($sformatf("rst_rdata_d%0d", d),  o_rdata(d),  8'h00);
      chk($sformatf("rst_err_d%0d", d),    o_err(d),    1'b0);
    end

    // Release reset and count the sweep: ready after exactly DEPTH edges
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk($sformatf("sweep_ready_d32_k%0d", k), ready0, (k >= 32));
      chk($sformatf("sweep_ready_d24_k%0d", k), ready1, (k >= 24));
    end

    // Every DEPTH=32 location reads back zero, one read per cycle
    for (int a = 0; a < 32; a++) begin
      drive(0, 1'b1, 1'b0, 5'(a), 8'h00, 1'b0);
      step();
      chk($sformatf("zero_rvalid_a%0d", a), rvalid0, 1'b1);
      chk($sformatf("zero_rdata_a%0d", a),  rdata0,  8'h00);
      chk($sformatf("zero_err_a%0d", a),    err0,    1'b0);
    end
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    step();
    chk("zero_rvalid_drop", rvalid0, 1'b0);

    // DEPTH=24 table: writes, reads, out-of-range on both sides of the boundary
    for (int i = 0; i < 15; i++) begin
      drive(1, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0);
      step();
      chk($sformatf("tbl%0d_rvalid", i), rvalid1, tbl[i].ev);
      chk($sformatf("tbl%0d_rdata", i),  rdata1,  tbl[i].erd);
      chk($sformatf("tbl%0d_err", i),    err1,    tbl[i].ee);
    end
    drive(1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);

    // clr with a simultaneous read: pre-clear data, then DEPTH cycles of not-ready
    drive(0, 1'b1, 1'b1, 5'd3, 8'h3C, 1'b0);
    step();
    drive(0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b1);
    step();
    chk("clrrd_rvalid", rvalid0, 1'b1);
    chk("clrrd_rdata",  rdata0,  8'h3C);
    chk("clrrd_ready",  ready0,  1'b0);
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step();
      chk($sformatf("clr_ready_k%0d", k), ready0, (k == 32));
      if (k == 1) chk("clr_rvalid_pulse", rvalid0, 1'b0);
    end
    drive(0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
    step();
    chk("postclr_rvalid", rvalid0, 1'b1);
    chk("postclr_rdata",  rdata0,  8'h00);
    drive(0, 1'b1, 1'b1, 5'd1, 8'hE7, 1'b0);
    step();
    drive(0, 1'b1, 1'b0, 5'd1, 8'h00, 1'b0);
    step();
    chk("e7_rdata", rdata0, 8'hE7);
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);

    // Write held through a clear window is accepted on the first ready cycle
    drive(1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
    step();
    drive(1, 1'b1, 1'b1, 5'd9, 8'h99, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("hwr_ready_k%0d", k), ready1, (k == 24));
      chk($sformatf("hwr_err_k%0d", k),   err1,   1'b0);
    end
    step();
    drive(1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    chk("hwr_acc_err", err1, 1'b0);
    drive(1, 1'b1, 1'b0, 5'd9, 8'h00, 1'b0);
    step();
    chk("hwr_rb_rvalid", rvalid1, 1'b1);
    chk("hwr_rb_rdata",  rdata1,  8'h99);

    // Read held through a clear window: no rvalid until accepted, then cleared data
    drive(1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
    step();
    drive(1, 1'b1, 1'b0, 5'd9, 8'h00, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("hrd_rvalid_k%0d", k), rvalid1, 1'b0);
      chk($sformatf("hrd_rdata_k%0d", k),  rdata1,  8'h99);
    end
    step();
    drive(1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    chk("hrd_acc_rvalid", rvalid1, 1'b1);
    chk("hrd_acc_rdata",  rdata1,  8'h00);
    step();
    chk("hrd_rvalid_drop", rvalid1, 1'b0);

    // Reset mid-sweep (idx=10) while the other instance has a read response pending
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
    step();
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 9)  drive(1, 1'b1, 1'b1, 5'd4, 8'h4E, 1'b0);
      if (k == 10) drive(1, 1'b1, 1'b0, 5'd4, 8'h00, 1'b0);
      step();
    end
    drive(1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    chk("prerst_rvalid_d24", rvalid1, 1'b1);
    chk("prerst_rdata_d24",  rdata1,  8'h4E);
    chk("prerst_rdata_d32",  rdata0,  8'hE7);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready_d32",  ready0,  1'b0);
    chk("midrst_rdata_d32",  rdata0,  8'h00);
    chk("midrst_rvalid_d24", rvalid1, 1'b0);
    chk("midrst_rdata_d24",  rdata1,  8'h00);
    chk("midrst_ready_d24",  ready1,  1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 31 || k == 32) chk($sformatf("rerst_ready_d32_k%0d", k), ready0, (k == 32));
      if (k == 23 || k == 24) chk($sformatf("rerst_ready_d24_k%0d", k), ready1, (k == 24));
    end

    // clr re-pulsed mid-sweep restarts the full DEPTH-cycle count
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
    step();
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    repeat (9) step();
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
    step();
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 23 || k == 31 || k == 32) chk($sformatf("reclr_ready_k%0d", k), ready0, (k == 32));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
